// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Signed operations run on magnitudes; the sign is fixed up in a single
// FIX cycle after WIDTH shift-add or restoring-division steps in CALC.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   localparam logic [WIDTH-1:0]   ZERO_W = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0]   ONES_W = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]      ZERO_C = {CW{1'b0}};
   localparam logic [CW-1:0]      ONE_C  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]      LOAD_C = CW'(WIDTH);

   // Conditional two's-complement negation, operand width.
   function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] v, input logic en);
      if (en) return ~v + ONE_W;
      else    return v;
   endfunction

   // Conditional two's-complement negation, double width.
   function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] v, input logic en);
      if (en) return ~v + ONE_2W;
      else    return v;
   endfunction

   logic [1:0]         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               is_div_q, is_div_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic               dbz_q, dbz_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;    // multiplicand or divisor magnitude
   logic [2*WIDTH-1:0] acc_q, acc_d;      // {partial, multiplier} or {remainder, quotient}
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;

   logic               signed_op_s, sign_a_s, sign_b_s;
   logic [WIDTH-1:0]   abs_a_s, abs_b_s;
   logic [WIDTH:0]     sum_s, trial_s;
   logic [2*WIDTH-1:0] mul_step_s, div_step_s, product_s;

   assign signed_op_s = ~op[0];
   assign sign_a_s    = signed_op_s & a[WIDTH-1];
   assign sign_b_s    = signed_op_s & b[WIDTH-1];
   assign abs_a_s     = cneg_w(a, sign_a_s);
   assign abs_b_s     = cneg_w(b, sign_b_s);

   // One shift-add step: add multiplicand when the current multiplier bit is set, then shift right.
   assign sum_s      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : ZERO_W)};
   assign mul_step_s = {sum_s, acc_q[WIDTH-1:1]};

   // One restoring step: shift the next dividend bit into the remainder and try to subtract.
   // A divisor of zero always "fits", which leaves quotient all ones and remainder = dividend.
   assign trial_s    = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
   assign div_step_s = trial_s[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                      : {trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

   assign product_s  = cneg_2w(acc_q, neg_res_q);

   // Next-state and datapath control for the IDLE/CALC/FIX sequence.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      dbz_d     = dbz_q;
      opnd_d    = opnd_q;
      acc_d     = acc_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cancel) begin
               state_d = S_IDLE;     // a flush drops any coincident start
            end else if (start) begin
               case (op)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     state_d   = S_CALC;
                     cnt_d     = LOAD_C;
                     is_div_d  = op[1];
                     neg_res_d = sign_a_s ^ sign_b_s;
                     neg_rem_d = sign_a_s;
                     dbz_d     = op[1] & (b == ZERO_W);
                     if (op[1]) begin
                        opnd_d = abs_b_s;
                        acc_d  = {ZERO_W, abs_a_s};
                     end else begin
                        opnd_d = abs_a_s;
                        acc_d  = {ZERO_W, abs_b_s};
                     end
                  end
                  OP_MTHI: hi_d = a;
                  OP_MTLO: lo_d = a;
                  default: state_d = S_IDLE;
               endcase
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CALC: begin
            if (cancel) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - ONE_C;
               if (is_div_q) acc_d = div_step_s;
               else          acc_d = mul_step_s;
               if (cnt_q == ONE_C) state_d = S_FIX;
               else                state_d = S_CALC;
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
            if (cancel) begin
               done_d = 1'b0;
            end else begin
               done_d = 1'b1;
               if (is_div_q) begin
                  hi_d = cneg_w(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);
                  lo_d = dbz_q ? ONES_W : cneg_w(acc_q[WIDTH-1:0], neg_res_q);
               end else begin
                  hi_d = product_s[2*WIDTH-1:WIDTH];
                  lo_d = product_s[WIDTH-1:0];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and result registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= ZERO_C;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dbz_q     <= 1'b0;
         opnd_q    <= ZERO_W;
         acc_q     <= {2*WIDTH{1'b0}};
         hi_q      <= ZERO_W;
         lo_q      <= ZERO_W;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         dbz_q     <= dbz_d;
         opnd_q    <= opnd_d;
         acc_q     <= acc_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        cancel;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_tests;
   int n_fail;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .cancel (cancel),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one mul/div op and watch it to completion. lat is the edge count
   // from the start edge to the first done pulse (0 if it never came).
   task automatic run(input logic [2:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                      input bit poke, output int lat, output int pulses, output bit busy_ok,
                      output bit busy_at_done);
      @(negedge clk);
      start = 1'b1; op = op_v; a = a_v; b = b_v;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0; pulses = 0; busy_ok = 1'b1; busy_at_done = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         if (poke && k == 5) begin
            start = 1'b1; op = OP_MULT; a = 32'h0000_0011; b = 32'h0000_0022;
         end else begin
            start = 1'b0;
         end
         if (poke && k == 8) begin
            a = 32'hDEAD_BEEF; b = 32'h0000_0000; op = OP_DIV;
         end
         @(posedge clk); #1;
         if (done) begin
            pulses++;
            if (lat == 0) begin
               lat = k;
               busy_at_done = busy;
            end
         end else if (lat == 0 && !busy) begin
            busy_ok = 1'b0;
         end
         if (lat != 0 && k >= lat + 3) break;
      end
      start = 1'b0;
   endtask

   int lat;
   int pulses;
   bit busy_ok;
   bit busy_at_done;

   initial begin
      n_tests = 0; n_fail = 0;
      reset = 1'b0; start = 1'b0; cancel = 1'b0; op = 3'b000; a = 32'h0; b = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", {63'h0, busy}, 64'h0);
      chk("rst_done", {63'h0, done}, 64'h0);
      chk("rst_hi", {32'h0, hi}, 64'h0);
      chk("rst_lo", {32'h0, lo}, 64'h0);
      reset = 1'b1;

      // MULT -3 * 5 = -15
      run(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, lat, pulses, busy_ok, busy_at_done);
      chk("mult_lat", 64'(lat), 64'd33);
      chk("mult_pulses", 64'(pulses), 64'd1);
      chk("mult_busy", {63'h0, busy_ok}, 64'h1);
      chk("mult_busy_done", {63'h0, busy_at_done}, 64'h0);
      chk("mult_hi", {32'h0, hi}, 64'hFFFF_FFFF);
      chk("mult_lo", {32'h0, lo}, 64'hFFFF_FFF1);

      // MULTU (2^32-1)^2 = FFFFFFFE_00000001
      run(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, pulses, busy_ok, busy_at_done);
      chk("multu_lat", 64'(lat), 64'd33);
      chk("multu_hi", {32'h0, hi}, 64'hFFFF_FFFE);
      chk("multu_lo", {32'h0, lo}, 64'h0000_0001);

      // MTHI writes hi at the start edge, no busy, no done
      @(negedge clk);
      start = 1'b1; op = OP_MTHI; a = 32'h1234_5678;
      @(posedge clk); #1;
      start = 1'b0;
      chk("mthi_hi", {32'h0, hi}, 64'h1234_5678);
      chk("mthi_lo", {32'h0, lo}, 64'h0000_0001);
      chk("mthi_busy", {63'h0, busy}, 64'h0);
      chk("mthi_done", {63'h0, done}, 64'h0);

      // MTLO writes lo
      @(negedge clk);
      start = 1'b1; op = OP_MTLO; a = 32'hCAFE_0001;
      @(posedge clk); #1;
      start = 1'b0;
      chk("mtlo_lo", {32'h0, lo}, 64'hCAFE_0001);
      chk("mtlo_hi", {32'h0, hi}, 64'h1234_5678);

      // DIV -7 / 2 = -3 rem -1
      run(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, lat, pulses, busy_ok, busy_at_done);
      chk("div_lat", 64'(lat), 64'd33);
      chk("div_lo", {32'h0, lo}, 64'hFFFF_FFFD);
      chk("div_hi", {32'h0, hi}, 64'hFFFF_FFFF);

      // DIV most-negative / -1 overflows to most-negative, rem 0
      run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, pulses, busy_ok, busy_at_done);
      chk("divovf_lo", {32'h0, lo}, 64'h8000_0000);
      chk("divovf_hi", {32'h0, hi}, 64'h0000_0000);

      // DIV 100 / -7 = -14 rem 2
      run(OP_DIV, 32'h0000_0064, 32'hFFFF_FFF9, 1'b0, lat, pulses, busy_ok, busy_at_done);
      chk("divneg_lo", {32'h0, lo}, 64'hFFFF_FFF2);
      chk("divneg_hi", {32'h0, hi}, 64'h0000_0002);

      // DIVU by zero
      run(OP_DIVU, 32'h0000_0064, 32'h0000_0000, 1'b0, lat, pulses, busy_ok, busy_at_done);
      chk("dbz_lat", 64'(lat), 64'd33);
      chk("dbz_lo", {32'h0, lo}, 64'hFFFF_FFFF);
      chk("dbz_hi", {32'h0, hi}, 64'h0000_0064);

      // DIV by zero with negative dividend: hi keeps a unmodified
      run(OP_DIV, 32'hFFFF_FF00, 32'h0000_0000, 1'b0, lat, pulses, busy_ok, busy_at_done);
      chk("sdbz_lo", {32'h0, lo}, 64'hFFFF_FFFF);
      chk("sdbz_hi", {32'h0, hi}, 64'hFFFF_FF00);

      // MULTU 3*4 with a spurious start at edge 5 and operand changes mid-run
      run(OP_MULTU, 32'h0000_0003, 32'h0000_0004, 1'b1, lat, pulses, busy_ok, busy_at_done);
      chk("poke_lat", 64'(lat), 64'd33);
      chk("poke_pulses", 64'(pulses), 64'd1);
      chk("poke_hi", {32'h0, hi}, 64'h0000_0000);
      chk("poke_lo", {32'h0, lo}, 64'h0000_000C);

      // DIV cancelled at edge 10
      @(negedge clk);
      start = 1'b1; op = OP_DIV; a = 32'h0000_0064; b = 32'h0000_0007;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
      chk("cancel_busy", {63'h0, busy}, 64'h0);
      pulses = done ? 1 : 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      chk("cancel_done", 64'(pulses), 64'd0);
      chk("cancel_hi", {32'h0, hi}, 64'h0000_0000);
      chk("cancel_lo", {32'h0, lo}, 64'h0000_000C);

      // cancel while idle drops a coincident start
      @(negedge clk);
      cancel = 1'b1; start = 1'b1; op = OP_MTLO; a = 32'h5555_5555;
      @(posedge clk); #1;
      cancel = 1'b0; start = 1'b0;
      chk("idlecancel_lo", {32'h0, lo}, 64'h0000_000C);
      chk("idlecancel_busy", {63'h0, busy}, 64'h0);

      // reset mid-MULT
      @(negedge clk);
      start = 1'b1; op = OP_MULT; a = 32'h0000_0007; b = 32'h0000_0009;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("midrst_prebusy", {63'h0, busy}, 64'h1);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("midrst_hi", {32'h0, hi}, 64'h0);
      chk("midrst_lo", {32'h0, lo}, 64'h0);
      chk("midrst_busy", {63'h0, busy}, 64'h0);
      chk("midrst_done", {63'h0, done}, 64'h0);
      reset = 1'b1;
      pulses = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      chk("midrst_nodone", 64'(pulses), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
